fir_engine: RTL and testbench



---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_round_sat.sv | 35 +++
 rtl/fir_engine.sv | 146 ++++++++++++++
 tb/tb_fir_engine.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the FIR engine and later effect blocks.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_e;

   // Accumulator width with enough guard bits that DEPTH full-scale products cannot overflow.
   function automatic int unsigned acc_w(input int unsigned width, input int unsigned coef_w,
                                         input int unsigned depth);
      return width + coef_w + $clog2(depth);
   endfunction

   // Half an LSB of the Q1.(coef_w-1) result, added before the shift for round-half-up.
   function automatic longint unsigned round_const(input int unsigned coef_w);
      return 64'(1) << (coef_w - 2);
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round half up, arithmetic shift by COEF_W-1, then clamp to the signed WIDTH-bit range.
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int unsigned WIDTH  = 12,
   parameter int unsigned COEF_W = 12,
   parameter int unsigned ACC_W  = 27
) (
   input  logic [ACC_W-1:0] acc,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned SHIFT = COEF_W - 1;
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(COEF_W));
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'(1) << (WIDTH - 1)) - 64'(1));
   // Two's complement: -max-1 is the bitwise inverse of max.
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [ACC_W-1:0] rounded;
   logic signed [ACC_W-1:0] shifted;

   // Round, scale back to sample units and saturate.
   always_comb begin
      rounded = $signed(acc) + RND;
      shifted = rounded >>> SHIFT;
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[WIDTH-1:0];
      end else begin
         result = shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fir_engine.sv
// Streaming signed FIR with a single time-multiplexed MAC, loadable taps and a bypass mode.
module fir_engine
   import fir_pkg::*;
#(
   parameter int unsigned WIDTH  = 12,
   parameter int unsigned COEF_W = 12,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_sample,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_sample,
   output logic                     out_valid,
   input  logic                     coef_we,
   input  logic [$clog2(DEPTH)-1:0] coef_addr,
   input  logic [COEF_W-1:0]        coef_data,
   output logic                     coef_ready,
   input  logic                     toggle_en,
   output logic                     enabled
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned ACC_W = acc_w(WIDTH, COEF_W, DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_e                   state_q;
   logic signed [WIDTH-1:0]  ring_q [DEPTH];
   logic signed [COEF_W-1:0] coef_q [DEPTH];
   logic [AW-1:0]            wr_ptr_q;
   logic [AW-1:0]            newest_q;
   logic [AW-1:0]            k_q;
   logic [AW-1:0]            tap_idx;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  prod;
   logic                     mode_q;
   logic                     enabled_q;
   logic                     out_valid_q;
   logic [WIDTH-1:0]         out_sample_q;
   logic [WIDTH-1:0]         rs_result;
   logic                     accept;
   logic                     coef_take;

   assign in_ready   = (state_q == IDLE);
   assign coef_ready = (state_q == IDLE);
   assign accept     = in_ready & in_valid;
   assign coef_take  = coef_ready & coef_we;
   assign out_sample = out_sample_q;
   assign out_valid  = out_valid_q;
   assign enabled    = enabled_q;

   // Tap k reads (newest - k) mod DEPTH; DEPTH need not be a power of two.
   always_comb begin
      if (k_q <= newest_q) begin
         tap_idx = newest_q - k_q;
      end else begin
         tap_idx = AW'(DEPTH) + newest_q - k_q;
      end
      prod = ACC_W'(ring_q[tap_idx]) * ACC_W'(coef_q[k_q]);
   end

   // Sample ring: accepted sample lands at wr_ptr, which then wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ring_q[i] <= '0;
         end
         wr_ptr_q <= '0;
      end else if (accept) begin
         ring_q[wr_ptr_q] <= in_sample;
         wr_ptr_q         <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
      end
   end

   // Coefficient file: writes land only while idle, so a running MAC never sees a change.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            coef_q[i] <= '0;
         end
      end else if (coef_take) begin
         coef_q[coef_addr] <= coef_data;
      end
   end

   // Footswitch flag; an accept on the same edge latches the old value into mode_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         enabled_q <= 1'b0;
      end else if (toggle_en) begin
         enabled_q <= ~enabled_q;
      end
   end

   // Control FSM: accept, DEPTH MAC cycles, then register the result for one pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         k_q          <= '0;
         newest_q     <= '0;
         mode_q       <= 1'b0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_q  <= MAC;
                  acc_q    <= '0;
                  k_q      <= '0;
                  newest_q <= wr_ptr_q;
                  mode_q   <= enabled_q;
               end
            end
            MAC: begin
               acc_q <= acc_q + prod;
               if (k_q == LAST) begin
                  state_q <= OUT;
               end else begin
                  k_q <= k_q + AW'(1);
               end
            end
            OUT: begin
               // Bypass still waits out the MAC so latency is mode-independent.
               out_sample_q <= mode_q ? rs_result : ring_q[newest_q];
               out_valid_q  <= 1'b1;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fir_round_sat #(
      .WIDTH  (WIDTH),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_round_sat (
      .acc    (acc_q),
      .result (rs_result)
   );

endmodule

// File: tb/tb_fir_engine.sv
// Scoreboard bench for fir_engine: a plain-arithmetic FIR model predicts every output.
module tb_fir_engine;

   localparam int W     = 12;
   localparam int CW    = 12;
   localparam int D     = 8;
   localparam int AW    = 3;
   localparam int CLK_P = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  in_sample;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_sample;
   logic          out_valid;
   logic          coef_we;
   logic [AW-1:0] coef_addr;
   logic [CW-1:0] coef_data;
   logic          coef_ready;
   logic          toggle_en;
   logic          enabled;

   typedef struct {
      int  val;
      time t;
   } exp_t;

   exp_t exp_q[$];
   int   hist[$];
   int   coef_m[D];
   bit   en_m;
   int   n_checks = 0;
   int   n_fail = 0;

   fir_engine #(
      .WIDTH  (W),
      .COEF_W (CW),
      .DEPTH  (D)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_sample  (in_sample),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .coef_ready (coef_ready),
      .toggle_en  (toggle_en),
      .enabled    (enabled)
   );

   always #(CLK_P / 2) clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: y = sat(floor((sum c[k]*x[n-k] + 2^10) / 2^11)), or x itself in bypass.
   function automatic int model_out(input int x);
      longint acc = 0;
      if (!en_m) return x;
      for (int k = 0; k < D; k++) acc += longint'(coef_m[k]) * longint'(hist[k]);
      acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
      if (acc > 2047) acc = 2047;
      if (acc < -2048) acc = -2048;
      return int'(acc);
   endfunction

   function automatic void model_reset();
      hist.delete();
      for (int k = 0; k < D; k++) begin
         hist.push_back(0);
         coef_m[k] = 0;
      end
      en_m = 1'b0;
      exp_q.delete();
   endfunction

   // Monitor: every out_valid pulse must match the oldest prediction, value and cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected out_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_sample", $signed(out_sample), e.val);
            check("out_valid time", $time, e.t);
         end
      end
   end

   task automatic apply_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      coef_we = 1'b0;
      toggle_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic send(input int x, input bit tog);
      int guard = 0;
      exp_t e;
      in_sample = W'(x);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("in_ready timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      toggle_en = tog;
      @(posedge clk);
      hist.push_front(x);
      void'(hist.pop_back());
      e.val = model_out(x);
      // Accept edge closes cycle t; the pulse is sampled mid cycle t+DEPTH+2.
      e.t = $time + (D + 1) * CLK_P + CLK_P / 2;
      exp_q.push_back(e);
      if (tog) en_m = !en_m;
      #1;
      in_valid = 1'b0;
      toggle_en = 1'b0;
   endtask

   task automatic write_coef(input int a, input int d, output bit saw_busy);
      int guard = 0;
      coef_we = 1'b1;
      coef_addr = AW'(a);
      coef_data = CW'(d);
      saw_busy = 1'b0;
      @(negedge clk);
      while (!coef_ready && guard < 50) begin
         saw_busy = 1'b1;
         @(negedge clk);
         guard++;
      end
      if (!coef_ready) begin
         check("coef_ready timeout", 0, 1);
      end else begin
         @(posedge clk);
         coef_m[a] = d;
         #1;
      end
      coef_we = 1'b0;
   endtask

   task automatic write_all(input int c);
      bit busy;
      for (int k = 0; k < D; k++) write_coef(k, c, busy);
   endtask

   task automatic toggle();
      toggle_en = 1'b1;
      @(posedge clk);
      en_m = !en_m;
      #1 toggle_en = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit busy;
      int ov_count;
      int r;
      in_sample = '0;
      coef_addr = '0;
      coef_data = '0;
      apply_reset();

      // Reset state
      @(negedge clk);
      check("reset out_valid", out_valid, 0);
      check("reset out_sample", out_sample, 0);
      check("reset enabled", enabled, 0);
      check("reset in_ready", in_ready, 1);
      check("reset coef_ready", coef_ready, 1);
      @(posedge clk);
      #1;

      // Bypass after reset: exact sample, busy for the whole MAC/OUT window
      send(123, 1'b0);
      for (int i = 1; i <= D + 1; i++) begin
         @(negedge clk);
         check("in_ready busy", in_ready, 0);
         check("coef_ready busy", coef_ready, 0);
      end
      @(posedge clk);
      #1;
      drain();

      // Near-unity single tap
      toggle();
      @(negedge clk);
      check("enabled on", enabled, 1);
      @(posedge clk);
      #1;
      write_coef(0, 2047, busy);
      for (int k = 1; k < D; k++) write_coef(k, 0, busy);
      send(1000, 1'b0);
      send(-500, 1'b0);

      // Moving average: impulse then step across two ring wraps
      write_all(256);
      for (int i = 0; i < D; i++) send(0, 1'b0);
      send(800, 1'b0);
      for (int i = 0; i < D + 1; i++) send(0, 1'b0);
      for (int i = 0; i < 20; i++) send(800, 1'b0);

      // Saturation at both rails
      write_all(2047);
      for (int i = 0; i < D; i++) send(0, 1'b0);
      for (int i = 0; i < D; i++) send(2047, 1'b0);
      for (int i = 0; i < D; i++) send(-2048, 1'b0);
      drain();

      // Coefficient write during MAC is held off until idle
      write_all(256);
      send(800, 1'b0);
      write_coef(0, 1024, busy);
      check("coef write stalled in MAC", busy, 1);
      send(800, 1'b0);

      // Toggle coincident with accept: that sample keeps the old mode
      send(400, 1'b1);
      send(-700, 1'b0);
      @(negedge clk);
      check("enabled after coincident toggle", enabled, en_m);
      @(posedge clk);
      #1;
      toggle();
      drain();

      // Reset mid-MAC: no output, history and taps cleared
      send(1500, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      apply_reset();
      ov_count = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) ov_count++;
      end
      check("out_valid after mid-MAC reset", ov_count, 0);
      check("enabled after reset", enabled, 0);
      @(posedge clk);
      #1;
      toggle();
      write_all(256);
      send(800, 1'b0);
      send(0, 1'b0);

      // Randomized traffic with interleaved tap writes and toggles
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) toggle();
         if (r <= 2) write_coef(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 4095)) - 2048,
                                busy);
         send(int'($urandom_range(0, 4095)) - 2048, 1'b0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
